note_scheduler: RTL and testbench



---
 rtl/note_scheduler.sv | 148 ++++++++++++++
 tb/tb_note_scheduler.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/note_scheduler.sv
// rtl/note_scheduler.sv - command FIFO plus start/release/reset pulse sequencer for one voice
module note_scheduler #(
    parameter int FCW_WIDTH   = 24,
    parameter int DUR_WIDTH   = 24,
    parameter int FIFO_DEPTH  = 8,
    parameter int FIN_TIMEOUT = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [FCW_WIDTH-1:0]          cmd_fcw,
    input  logic [DUR_WIDTH-1:0]          cmd_duration,
    input  logic                          sample_tick,
    input  logic                          flush,
    input  logic                          note_finished,
    output logic                          note_start,
    output logic                          note_release,
    output logic                          note_reset,
    output logic                          global_reset,
    output logic [FCW_WIDTH-1:0]          note_fcw,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          timeout_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (FIN_TIMEOUT > 1) ? $clog2(FIN_TIMEOUT) : 1;
    localparam logic [AW:0]   DEPTH_C = FIFO_DEPTH[AW:0];
    localparam logic [TW-1:0] TO_LAST = TW'(FIN_TIMEOUT - 1);

    typedef enum logic [5:0] {
        S_IDLE     = 6'b000001,
        S_START    = 6'b000010,
        S_PLAY     = 6'b000100,
        S_RELEASE  = 6'b001000,
        S_WAIT_FIN = 6'b010000,
        S_RESET    = 6'b100000
    } state_t;

    state_t                           state;
    logic [FCW_WIDTH+DUR_WIDTH-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]                    wr_ptr;
    logic [AW-1:0]                    rd_ptr;
    logic [DUR_WIDTH-1:0]             dur_cnt;
    logic [TW-1:0]                    to_cnt;
    logic                             full;
    logic                             empty;
    logic                             push;
    logic                             pop;
    logic [FCW_WIDTH-1:0]             head_fcw;
    logic [DUR_WIDTH-1:0]             head_dur;

    assign full      = (fifo_count == DEPTH_C);
    assign empty     = (fifo_count == '0);
    assign cmd_ready = !full && !flush;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == S_IDLE) && !empty && !flush;
    assign {head_fcw, head_dur} = mem[rd_ptr];

    // Pulses come straight from the registered state so no input can glitch them.
    assign note_start   = (state == S_START);
    assign note_release = (state == S_RELEASE);
    assign note_reset   = (state == S_RESET);
    assign busy         = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_fcw, cmd_duration};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_count   <= '0;
            dur_cnt      <= '0;
            to_cnt       <= '0;
            note_fcw     <= '0;
            timeout_err  <= 1'b0;
            global_reset <= 1'b0;
        end else begin
            global_reset <= flush;
            if (flush) begin
                // note_fcw and timeout_err deliberately survive a flush.
                state      <= S_IDLE;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                fifo_count <= '0;
                dur_cnt    <= '0;
                to_cnt     <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
                case ({push, pop})
                    2'b10:   fifo_count <= fifo_count + (AW+1)'(1);
                    2'b01:   fifo_count <= fifo_count - (AW+1)'(1);
                    default: fifo_count <= fifo_count;
                endcase

                case (state)
                    S_IDLE: begin
                        if (!empty) begin
                            note_fcw <= head_fcw;
                            dur_cnt  <= head_dur;
                            state    <= S_START;
                        end
                    end
                    S_START: begin
                        state <= S_PLAY;
                    end
                    S_PLAY: begin
                        if (dur_cnt == '0) begin
                            state <= S_RELEASE;
                        end else if (sample_tick) begin
                            dur_cnt <= dur_cnt - DUR_WIDTH'(1);
                        end
                    end
                    S_RELEASE: begin
                        to_cnt <= '0;
                        state  <= S_WAIT_FIN;
                    end
                    S_WAIT_FIN: begin
                        if (note_finished) begin
                            state <= S_RESET;
                        end else if (to_cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                            state       <= S_RESET;
                        end else begin
                            to_cnt <= to_cnt + TW'(1);
                        end
                    end
                    S_RESET: begin
                        state <= S_IDLE;
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_note_scheduler.sv
// tb/tb_note_scheduler.sv - vector table, random notes against a timing model, fifo/flush/reset sequences
module tb_note_scheduler;
    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_fcw;
    logic [23:0] cmd_duration;
    logic        sample_tick;
    logic        flush;
    logic        note_finished;
    logic        note_start;
    logic        note_release;
    logic        note_reset;
    logic        global_reset;
    logic [23:0] note_fcw;
    logic        busy;
    logic [3:0]  fifo_count;
    logic        timeout_err;

    note_scheduler dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_fcw(cmd_fcw), .cmd_duration(cmd_duration), .sample_tick(sample_tick),
        .flush(flush), .note_finished(note_finished), .note_start(note_start),
        .note_release(note_release), .note_reset(note_reset), .global_reset(global_reset),
        .note_fcw(note_fcw), .busy(busy), .fifo_count(fifo_count), .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] fcw;
        logic [23:0] dur;
        int          period;
        logic        fin;
        int          exp_rel;
        int          exp_rst;
    } vec_t;

    int n_pass = 0;
    int n_total = 0;
    int n_start = 0;
    int n_rel = 0;
    int n_rst = 0;
    int n_grst = 0;
    logic err_model = 1'b0;
    logic [23:0] q[$];

    always @(posedge clk) begin
        if (note_start)   n_start++;
        if (note_release) n_rel++;
        if (note_reset)   n_rst++;
        if (global_reset) n_grst++;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic step_w();
        logic [23:0] e;
        step();
        if (note_start) begin
            if (q.size() == 0) check("unexpected_start", 1, 0);
            else begin
                e = q.pop_front();
                check("fifo_order_fcw", note_fcw, e);
            end
        end
    endtask

    // Release index i counts edges spent in PLAY; ticks land on edges where i % period == period-1.
    task automatic run_note(input vec_t v);
        int s_st, s_rl, s_rs, rel_i, rst_i;
        s_st = n_start; s_rl = n_rel; s_rs = n_rst;
        note_finished = v.fin;
        cmd_valid = 1'b1; cmd_fcw = v.fcw; cmd_duration = v.dur;
        step();
        cmd_valid = 1'b0;
        check("count_after_push", fifo_count, 1);
        step();
        check("start_pulse", note_start, 1);
        check("note_fcw", note_fcw, v.fcw);
        check("count_after_pop", fifo_count, 0);
        step();
        rel_i = -1;
        for (int i = 0; i < 200; i++) begin
            sample_tick = ((i % v.period) == v.period - 1);
            step();
            if (note_release) begin
                rel_i = i;
                break;
            end
        end
        sample_tick = 1'b0;
        check("release_index", rel_i, v.exp_rel);
        rst_i = -1;
        for (int j = 1; j <= 1200; j++) begin
            step();
            if (note_reset) begin
                rst_i = j;
                break;
            end
        end
        check("reset_index", rst_i, v.exp_rst);
        step();
        check("idle_after_reset", busy, 0);
        step();
        check("start_count", n_start - s_st, 1);
        check("release_count", n_rel - s_rl, 1);
        check("reset_count", n_rst - s_rs, 1);
        if (!v.fin) err_model = 1'b1;
        check("timeout_err", timeout_err, err_model);
        note_finished = 1'b1;
    endtask

    vec_t tbl[5];
    vec_t r;
    int   n_acc, s_st, s_rl, s_rs, s_gr;
    logic [23:0] f;

    initial begin
        tbl[0] = '{24'h001234, 24'd3, 4, 1'b1, 12, 2};
        tbl[1] = '{24'hABCDEF, 24'd0, 1, 1'b1, 0, 2};
        tbl[2] = '{24'h000001, 24'd1, 1, 1'b1, 1, 2};
        tbl[3] = '{24'hFFFFFF, 24'd5, 2, 1'b1, 10, 2};
        tbl[4] = '{24'h0F0F0F, 24'd2, 3, 1'b0, 6, 1025};

        rst = 1'b1; cmd_valid = 1'b0; cmd_fcw = '0; cmd_duration = '0;
        sample_tick = 1'b0; flush = 1'b0; note_finished = 1'b1;
        step(); step();
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_busy", busy, 0);
        check("rst_note_fcw", note_fcw, 0);
        check("rst_pulses", {note_start, note_release, note_reset, global_reset}, 0);
        check("rst_timeout_err", timeout_err, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 5; i++) run_note(tbl[i]);

        for (int i = 0; i < 10; i++) begin
            r.fcw = 24'($urandom);
            r.dur = 24'($urandom_range(0, 6));
            r.period = $urandom_range(1, 4);
            r.fin = 1'b1;
            r.exp_rel = r.period * int'(r.dur);
            r.exp_rst = 2;
            run_note(r);
        end

        // Fill: first note parks in PLAY (no ticks), rest queue until full.
        s_st = n_start;
        n_acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (!cmd_ready) break;
            cmd_valid = 1'b1; cmd_fcw = 24'($urandom); cmd_duration = 24'd1;
            q.push_back(cmd_fcw);
            n_acc++;
            step_w();
        end
        cmd_valid = 1'b0;
        check("fill_accepted", n_acc, 9);
        check("fill_fifo_count", fifo_count, 8);
        check("fill_cmd_ready", cmd_ready, 0);
        sample_tick = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step_w();
            if (q.size() == 0 && !busy) break;
        end
        sample_tick = 1'b0;
        check("drain_queue_empty", q.size(), 0);
        check("drain_busy", busy, 0);
        check("drain_starts", n_start - s_st, 9);

        // Flush during PLAY with 3 queued.
        for (int i = 0; i < 4; i++) begin
            cmd_valid = 1'b1; cmd_fcw = 24'h000100 + 24'(i); cmd_duration = 24'd5;
            step();
        end
        cmd_valid = 1'b0;
        check("pre_flush_count", fifo_count, 3);
        check("pre_flush_busy", busy, 1);
        s_rl = n_rel; s_rs = n_rst; s_gr = n_grst;
        flush = 1'b1; cmd_valid = 1'b1; cmd_fcw = 24'h00DEAD; cmd_duration = 24'd1;
        #1;
        check("flush_cmd_ready", cmd_ready, 0);
        step();
        flush = 1'b0; cmd_valid = 1'b0;
        check("flush_global_reset", global_reset, 1);
        check("flush_count", fifo_count, 0);
        check("flush_busy", busy, 0);
        check("flush_keeps_fcw", note_fcw, 24'h000100);
        step();
        check("flush_grst_one_cycle", global_reset, 0);
        check("flush_cmd_ignored", fifo_count, 0);
        step(); step(); step();
        check("flush_no_release", n_rel - s_rl, 0);
        check("flush_no_reset", n_rst - s_rs, 0);
        check("flush_grst_count", n_grst - s_gr, 1);
        check("flush_still_idle", busy, 0);

        // Asynchronous reset mid-PLAY.
        f = 24'h0A5A5A;
        cmd_valid = 1'b1; cmd_fcw = f; cmd_duration = 24'd5;
        step();
        cmd_valid = 1'b0;
        step(); step();
        check("pre_rst_busy", busy, 1);
        check("pre_rst_fcw", note_fcw, f);
        s_rl = n_rel; s_rs = n_rst;
        #2 rst = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_fcw", note_fcw, 0);
        check("async_count", fifo_count, 0);
        check("async_ready", cmd_ready, 1);
        check("async_err", timeout_err, 0);
        check("async_pulses", {note_start, note_release, note_reset, global_reset}, 0);
        step();
        rst = 1'b0;
        step(); step();
        check("post_rst_no_pulses", (n_rel - s_rl) + (n_rst - s_rs), 0);
        check("post_rst_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
